// File: rtl/uart_imem_loader.sv
// UART boot loader: 8N1 receiver feeding a word assembler that writes instruction memory.
// Optional trailing-checksum verification is compiled in with `define LOADER_CHECKSUM_EN.
module uart_imem_loader #(
  parameter int CLK_HZ    = 50000000,
  parameter int BIT_RATE  = 9600,
  parameter int WORD_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              uart_rxd,
  input  logic              uart_rx_en,
  output logic              uart_rx_valid,
  output logic [7:0]        uart_rx_data,
  output logic              uart_rx_break,
  output logic              frame_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              write_done,
  output logic              overflow,
  output logic              chk_err
);

  localparam int CPB    = CLK_HZ / BIT_RATE;
  localparam int HALF   = CPB / 2;
  localparam int NBYTES = WORD_W / 8;
  localparam int CNT_W  = $clog2(CPB + 1);
  localparam int IDX_W  = $clog2(NBYTES + 1);

  localparam logic [CNT_W-1:0] CPB_M1  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        rx_state_q;
  logic             rxd_s1_q, rxd_s2_q, rxd_s3_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_shift_q;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q, rx_break_q, rx_ferr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_s3_q   <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_break_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rxd_s1_q   <= uart_rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_s3_q   <= rxd_s2_q;
      rx_valid_q <= 1'b0;
      rx_break_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (uart_rx_en && rxd_s3_q && !rxd_s2_q) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= '0;
          end
        end
        RX_START: begin
          // A start bit that is high again at mid-bit was only a glitch.
          if (rx_cnt_q == HALF_M1) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rxd_s2_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == CPB_M1) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rxd_s2_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == CPB_M1) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
            if (rxd_s2_q) begin
              rx_valid_q <= 1'b1;
              rx_data_q  <= rx_shift_q;
            end else if (rx_shift_q == 8'h00) begin
              rx_break_q <= 1'b1;
            end else begin
              rx_ferr_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign uart_rx_valid = rx_valid_q;
  assign uart_rx_data  = rx_data_q;
  assign uart_rx_break = rx_break_q;
  assign frame_err     = rx_ferr_q;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {LD_LOAD, LD_DONE, LD_CHECK} ld_state_t;
  logic [WORD_W-1:0] sum_q;
  logic              chk_q;
`else
  typedef enum logic [1:0] {LD_LOAD, LD_DONE} ld_state_t;
`endif

  ld_state_t         ld_state_q;
  logic [IDX_W-1:0]  byte_idx_q;
  logic [IDX_W-1:0]  slot;
  logic [WORD_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic              done_q, ovf_q, we_q;
  logic [ADDR_W-1:0] maddr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              last_byte;

  assign slot      = (LSB_FIRST != 0) ? byte_idx_q : IDX_W'(NBYTES - 1) - byte_idx_q;
  assign last_byte = (byte_idx_q == IDX_W'(NBYTES - 1));

  always_comb begin
    word_d = word_q;
    for (int i = 0; i < NBYTES; i++) begin
      if (IDX_W'(i) == slot) word_d[8*i +: 8] = rx_data_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ld_state_q <= LD_LOAD;
      byte_idx_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      we_q       <= 1'b0;
      maddr_q    <= '0;
      wdata_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
      chk_q      <= 1'b0;
`endif
    end else begin
      we_q <= 1'b0;
      if (rx_break_q) begin
        ld_state_q <= LD_LOAD;
        byte_idx_q <= '0;
        addr_q     <= '0;
        count_q    <= '0;
        done_q     <= 1'b0;
        ovf_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_q      <= '0;
        chk_q      <= 1'b0;
`endif
      end else if (rx_valid_q && ld_state_q != LD_DONE) begin
        word_q     <= word_d;
        byte_idx_q <= last_byte ? '0 : byte_idx_q + IDX_W'(1);
        if (last_byte) begin
          case (ld_state_q)
`ifdef LOADER_CHECKSUM_EN
            LD_CHECK: begin
              done_q     <= 1'b1;
              chk_q      <= ((sum_q + word_d) != '0);
              ld_state_q <= LD_DONE;
            end
`endif
            LD_LOAD: begin
              if (&word_d) begin
`ifdef LOADER_CHECKSUM_EN
                ld_state_q <= LD_CHECK;
`else
                done_q     <= 1'b1;
                ld_state_q <= LD_DONE;
`endif
              end else begin
                we_q    <= 1'b1;
                maddr_q <= addr_q;
                wdata_q <= word_d;
                count_q <= count_q + (ADDR_W+1)'(1);
`ifdef LOADER_CHECKSUM_EN
                sum_q   <= sum_q + word_d;
`endif
                // The last address ends the load; the pointer never wraps.
                if (&addr_q) begin
                  ovf_q      <= 1'b1;
                  done_q     <= 1'b1;
                  ld_state_q <= LD_DONE;
                end else begin
                  addr_q <= addr_q + ADDR_W'(1);
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign mem_we     = we_q;
  assign mem_addr   = maddr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = count_q;
  assign write_done = done_q;
  assign overflow   = ovf_q;
`ifdef LOADER_CHECKSUM_EN
  assign chk_err    = chk_q;
`else
  assign chk_err    = 1'b0;
`endif

endmodule
